// File: rtl/i2c_init_seq_pkg.sv
// Shared definitions for the I2C init sequencer: state encoding, default device address
// and the packet-slice offset helper used to unpack the flat packet table.
package i2c_init_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } state_e;

    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h21;

    // LSB position of packet idx inside a flat table of data_w-bit packets
    function automatic int unsigned pkt_lsb(input int unsigned idx, input int unsigned data_w);
        return idx * data_w;
    endfunction

endpackage

// File: rtl/i2c_init_seq.sv
// Walks a flat table of config bytes through the i2c_master start/ready handshake, with
// inter-packet gap, accept timeout, done pulse, progress index and optional repeat.
module i2c_init_seq
    import i2c_init_seq_pkg::*;
#(
    parameter int unsigned MAX_PACKETS = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned GAP_W       = 8,
    parameter int unsigned TIMEOUT     = 1023,
    parameter int unsigned CNT_W       = $clog2(MAX_PACKETS + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          repeat_mode,
    input  logic [ADDR_W-1:0]             dev_addr,
    input  logic [MAX_PACKETS*DATA_W-1:0] flat_i2c_data,
    input  logic [CNT_W-1:0]              packets,
    input  logic [GAP_W-1:0]              gap_cycles,
    input  logic                          m_ready,
    output logic                          m_start,
    output logic [ADDR_W-1:0]             m_addr,
    output logic [DATA_W-1:0]             m_data,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [CNT_W-1:0]              packet_idx
);

    localparam int unsigned IDX_W = (MAX_PACKETS > 1) ? $clog2(MAX_PACKETS) : 1;
    localparam int unsigned TBL_N = 2 ** IDX_W;
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PACKETS);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_e              state_q,   state_d;
    logic [CNT_W-1:0]    idx_q,     idx_d;
    logic [CNT_W-1:0]    pkts_q,    pkts_d;
    logic [GAP_W-1:0]    gap_q,     gap_d;
    logic [GAP_W-1:0]    gcnt_q,    gcnt_d;
    logic [TMO_W-1:0]    tmo_q,     tmo_d;
    logic                m_start_q, m_start_d;
    logic [ADDR_W-1:0]   m_addr_q,  m_addr_d;
    logic [DATA_W-1:0]   m_data_q,  m_data_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic                err_q,     err_d;

    logic [DATA_W-1:0]   pkt_tbl [TBL_N];
    logic [CNT_W-1:0]    idx_nxt;
    logic [DATA_W-1:0]   pkt_cur;
    logic [DATA_W-1:0]   pkt_nxt;

    // Table padded to a power of two so any IDX_W-bit index is in range
    for (genvar k = 0; k < TBL_N; k++) begin : g_tbl
        if (k < MAX_PACKETS) begin : g_pkt
            assign pkt_tbl[k] = flat_i2c_data[pkt_lsb(k, DATA_W) +: DATA_W];
        end else begin : g_pad
            assign pkt_tbl[k] = '0;
        end
    end

    assign idx_nxt = idx_q + CNT_W'(1);
    assign pkt_cur = pkt_tbl[IDX_W'(idx_q)];
    assign pkt_nxt = pkt_tbl[IDX_W'(idx_nxt)];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            pkts_q    <= '0;
            gap_q     <= '0;
            gcnt_q    <= '0;
            tmo_q     <= '0;
            m_start_q <= 1'b0;
            m_addr_q  <= '0;
            m_data_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pkts_q    <= pkts_d;
            gap_q     <= gap_d;
            gcnt_q    <= gcnt_d;
            tmo_q     <= tmo_d;
            m_start_q <= m_start_d;
            m_addr_q  <= m_addr_d;
            m_data_q  <= m_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state and registered-output logic; entering SEND from WAIT/GAP raises m_start at once
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pkts_d    = pkts_q;
        gap_d     = gap_q;
        gcnt_d    = gcnt_q;
        tmo_d     = tmo_q;
        m_start_d = m_start_q;
        m_addr_d  = m_addr_q;
        m_data_d  = m_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SEND;
                    m_addr_d = dev_addr;
                    pkts_d   = (packets > MAX_CNT) ? MAX_CNT : packets;
                    gap_d    = gap_cycles;
                    idx_d    = '0;
                    tmo_d    = '0;
                    err_d    = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            ST_SEND: begin
                if (pkts_q == '0) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (m_start_q && !m_ready) begin
                    state_d   = ST_WAIT;
                    m_start_d = 1'b0;
                end else if (m_start_q && (TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
                    state_d   = ST_ERROR;
                    m_start_d = 1'b0;
                    busy_d    = 1'b0;
                    err_d     = 1'b1;
                end else begin
                    m_start_d = 1'b1;
                    m_data_d  = pkt_cur;
                    if (m_start_q) begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (m_ready) begin
                    if (idx_q == pkts_q - CNT_W'(1)) begin
                        done_d = 1'b1;
                        if (repeat_mode && start) begin
                            state_d   = ST_SEND;
                            idx_d     = '0;
                            m_start_d = 1'b1;
                            m_data_d  = pkt_tbl[0];
                            tmo_d     = '0;
                        end else begin
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        idx_d = idx_nxt;
                        if (gap_q != '0) begin
                            state_d = ST_GAP;
                            gcnt_d  = '0;
                        end else begin
                            state_d   = ST_SEND;
                            m_start_d = 1'b1;
                            m_data_d  = pkt_nxt;
                            tmo_d     = '0;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gcnt_q == gap_q - GAP_W'(1)) begin
                    state_d   = ST_SEND;
                    m_start_d = 1'b1;
                    m_data_d  = pkt_cur;
                    tmo_d     = '0;
                end else begin
                    gcnt_d = gcnt_q + GAP_W'(1);
                end
            end
            ST_DONE, ST_ERROR: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign m_start    = m_start_q;
    assign m_addr     = m_addr_q;
    assign m_data     = m_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = err_q;
    assign packet_idx = idx_q;

endmodule

// File: tb/tb_i2c_init_seq.sv
// Randomised scoreboard bench for i2c_init_seq with a behavioural i2c_master model.
module tb_i2c_init_seq;
    import i2c_init_seq_pkg::*;

    localparam int unsigned MAXP = 8;
    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 7;
    localparam int unsigned GW   = 8;
    localparam int unsigned TMO  = 16;
    localparam int unsigned CW   = $clog2(MAXP + 1);
    localparam int          MREADY_N = 20;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              repeat_mode = 1'b0;
    logic [AW-1:0]     dev_addr = '0;
    logic [MAXP*DW-1:0] flat = '0;
    logic [CW-1:0]     packets = '0;
    logic [GW-1:0]     gap_cycles = '0;
    logic              m_ready;
    logic              m_start;
    logic [AW-1:0]     m_addr;
    logic [DW-1:0]     m_data;
    logic              busy;
    logic              done;
    logic              error;
    logic [CW-1:0]     packet_idx;

    always #5 clk = ~clk;

    i2c_init_seq #(
        .MAX_PACKETS(MAXP), .DATA_W(DW), .ADDR_W(AW), .GAP_W(GW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .repeat_mode(repeat_mode),
        .dev_addr(dev_addr), .flat_i2c_data(flat), .packets(packets),
        .gap_cycles(gap_cycles), .m_ready(m_ready), .m_start(m_start),
        .m_addr(m_addr), .m_data(m_data), .busy(busy), .done(done),
        .error(error), .packet_idx(packet_idx)
    );

    // i2c_master model: ready drops one cycle after start, returns MREADY_N cycles later
    bit hang = 1'b0;
    int mcnt = 0;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ready <= 1'b1;
            mcnt    <= 0;
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) m_ready <= 1'b1;
        end else if (m_start && m_ready && !hang) begin
            m_ready <= 1'b0;
            mcnt    <= MREADY_N;
        end
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [CW-1:0] idx;
        bit            from_start;
        int            lat;
    } xfer_t;

    typedef struct {
        bit from_start;
        int lat;
    } done_t;

    xfer_t xq[$];
    done_t dq[$];
    xfer_t mon_x;
    done_t mon_d;
    logic [DW-1:0] pk_bytes [MAXP];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rdy_rise_cyc = 0;
    int ms_rise_cyc = 0;
    int n_xfer = 0;
    int n_done = 0;
    logic ms_prev = 1'b0;
    logic rdy_prev = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every m_start rise and every done pulse
    always @(negedge clk) begin
        if (reset) begin
            if (m_ready && !rdy_prev) rdy_rise_cyc = cyc;
            if (m_start && !ms_prev) begin
                ms_rise_cyc = cyc;
                n_xfer++;
                chk("xfer_expected", 64'(xq.size() != 0), 64'(1));
                if (xq.size() != 0) begin
                    mon_x = xq.pop_front();
                    chk("m_addr", 64'(m_addr), 64'(mon_x.addr));
                    chk("m_data", 64'(m_data), 64'(mon_x.data));
                    chk("packet_idx", 64'(packet_idx), 64'(mon_x.idx));
                    chk("m_start_latency",
                        64'(cyc - (mon_x.from_start ? start_cyc : rdy_rise_cyc)), 64'(mon_x.lat));
                end
            end
            if (done) begin
                n_done++;
                chk("done_expected", 64'(dq.size() != 0), 64'(1));
                if (dq.size() != 0) begin
                    mon_d = dq.pop_front();
                    chk("done_latency",
                        64'(cyc - (mon_d.from_start ? start_cyc : rdy_rise_cyc)), 64'(mon_d.lat));
                end
            end
        end
        ms_prev  = m_start;
        rdy_prev = m_ready;
    end

    task automatic rand_bytes();
        for (int k = 0; k < MAXP; k++) pk_bytes[k] = DW'($urandom);
    endtask

    // Reference model: one pass sends min(packets,MAXP) bytes in table order
    task automatic push_pass(input int n, input int gap, input bit first, input logic [AW-1:0] addr);
        done_t d;
        for (int k = 0; k < n; k++) begin
            xfer_t x;
            x.addr       = addr;
            x.data       = pk_bytes[k];
            x.idx        = CW'(k);
            x.from_start = first && (k == 0);
            x.lat        = (k == 0) ? (first ? 2 : 1) : 1 + gap;
            xq.push_back(x);
        end
        d.from_start = (n == 0);
        d.lat        = (n == 0) ? 2 : 1;
        dq.push_back(d);
    endtask

    task automatic drive_start(input int n_req, input int gap, input logic [AW-1:0] addr, input bit rep);
        @(negedge clk);
        flat = '0;
        for (int k = MAXP - 1; k >= 0; k--) flat = (flat << DW) | (MAXP*DW)'(pk_bytes[k]);
        dev_addr    = addr;
        packets     = CW'(n_req);
        gap_cycles  = GW'(gap);
        repeat_mode = rep;
        start       = 1'b1;
        start_cyc   = cyc;
    endtask

    task automatic wait_idle(input int budget);
        int w = 0;
        while (busy && w < budget) begin
            @(negedge clk);
            w++;
        end
        chk("seq_completes", 64'(busy), 64'(0));
    endtask

    task automatic run_seq(input int n_req, input int gap, input logic [AW-1:0] addr);
        int n  = (n_req > MAXP) ? MAXP : n_req;
        int x0 = n_xfer;
        int d0 = n_done;
        drive_start(n_req, gap, addr, 1'b0);
        push_pass(n, gap, 1'b1, addr);
        repeat (2) @(negedge clk);
        wait_idle(3000);
        repeat (3) @(negedge clk);
        chk("xfers_sent", 64'(n_xfer - x0), 64'(n));
        chk("done_pulses", 64'(n_done - d0), 64'(1));
        chk("error_low", 64'(error), 64'(0));
        chk("scoreboard_empty", 64'(xq.size() + dq.size()), 64'(0));
        repeat (8) @(negedge clk);
        chk("no_retrigger", 64'(n_xfer - x0), 64'(n));
        chk("busy_low_held", 64'(busy), 64'(0));
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int w;
        int x0;
        int d0;
        int g;
        logic [AW-1:0] a;

        repeat (3) @(negedge clk);
        chk("rst_m_start", 64'(m_start), 64'(0));
        chk("rst_m_addr", 64'(m_addr), 64'(0));
        chk("rst_m_data", 64'(m_data), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_error", 64'(error), 64'(0));
        chk("rst_idx", 64'(packet_idx), 64'(0));
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // three fixed packets to the default address, no gap
        rand_bytes();
        pk_bytes[0] = 8'h12; pk_bytes[1] = 8'h34; pk_bytes[2] = 8'h56;
        run_seq(3, 0, DEFAULT_DEV_ADDR);

        // empty sequence
        rand_bytes();
        run_seq(0, 3, AW'($urandom));

        // five-cycle inter-packet gap
        rand_bytes();
        run_seq(2, 5, AW'($urandom));

        // accept timeout with a master that never takes the request
        rand_bytes();
        a = AW'($urandom);
        hang = 1'b1;
        drive_start(2, 0, a, 1'b0);
        mon_x.addr = a; mon_x.data = pk_bytes[0]; mon_x.idx = '0;
        mon_x.from_start = 1'b1; mon_x.lat = 2;
        xq.push_back(mon_x);
        w = 0;
        while (!error && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("timeout_error", 64'(error), 64'(1));
        chk("timeout_m_start", 64'(m_start), 64'(0));
        chk("timeout_busy", 64'(busy), 64'(0));
        chk("timeout_cycles", 64'(cyc - ms_rise_cyc), 64'(TMO));
        hang  = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("error_sticky", 64'(error), 64'(1));
        chk("timeout_scoreboard", 64'(xq.size() + dq.size()), 64'(0));
        rand_bytes();
        run_seq(2, 1, AW'($urandom));

        // repeat mode: three passes, start dropped during the third
        rand_bytes();
        g  = int'($urandom_range(0, 3));
        a  = AW'($urandom);
        x0 = n_xfer;
        d0 = n_done;
        drive_start(2, g, a, 1'b1);
        push_pass(2, g, 1'b1, a);
        push_pass(2, g, 1'b0, a);
        push_pass(2, g, 1'b0, a);
        w = 0;
        while ((n_xfer - x0) < 5 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk("repeat_third_pass", 64'(n_xfer - x0), 64'(5));
        start = 1'b0;
        wait_idle(2000);
        repeat (3) @(negedge clk);
        chk("repeat_xfers", 64'(n_xfer - x0), 64'(6));
        chk("repeat_dones", 64'(n_done - d0), 64'(3));
        chk("repeat_scoreboard", 64'(xq.size() + dq.size()), 64'(0));
        repeat_mode = 1'b0;
        repeat (6) @(negedge clk);
        chk("repeat_stopped", 64'(n_xfer - x0), 64'(6));

        // asynchronous reset while waiting on packet 1
        rand_bytes();
        pk_bytes[1] = pk_bytes[1] | 8'h01;
        a  = AW'($urandom_range(1, 127));
        x0 = n_xfer;
        drive_start(3, 0, a, 1'b0);
        push_pass(3, 0, 1'b1, a);
        w = 0;
        while ((n_xfer - x0) < 2 && w < 500) begin
            @(negedge clk);
            w++;
        end
        w = 0;
        while (m_start && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("idx_before_reset", 64'(packet_idx), 64'(1));
        reset = 1'b0;
        #1;
        chk("arst_m_start", 64'(m_start), 64'(0));
        chk("arst_m_addr", 64'(m_addr), 64'(0));
        chk("arst_m_data", 64'(m_data), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_done", 64'(done), 64'(0));
        chk("arst_error", 64'(error), 64'(0));
        chk("arst_idx", 64'(packet_idx), 64'(0));
        xq.delete();
        dq.delete();
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // request beyond table depth is clamped
        rand_bytes();
        run_seq(12, int'($urandom_range(0, 2)), AW'($urandom));

        for (int i = 0; i < 4; i++) begin
            rand_bytes();
            run_seq(int'($urandom_range(0, 10)), int'($urandom_range(0, 4)), AW'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
